// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: synchronises 8 edge-triggered lines,
// latches pending status and presents one masked vector to the core.
module interrupt_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int VW          = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_enable,
  input  logic               mask_wrt,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               int_ack,
  input  logic               clear_all,
  output logic [NUM_IRQ-1:0] irq_masks,
  output logic [NUM_IRQ-1:0] irq_status,
  output logic               int_request,
  output logic [VW-1:0]      int_vector
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] last_q;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] stat_q, stat_d;
  logic               req_q, req_d;
  logic [VW-1:0]      vec_q, vec_d;

  logic [NUM_IRQ-1:0] sync_out;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [VW-1:0]      sel;
  logic               ack_hit;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~last_q;
  assign eligible = stat_q & mask_q;
  assign ack_hit  = int_ack && (state_q == REQ);

  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = VW'(i);
    end
  end

  always_comb begin
    mask_d = mask_wrt ? mask_in : mask_q;
  end

  // Set beats a same-cycle ack of that bit; clear_all beats everything.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (clear_all) begin
        stat_d[i] = 1'b0;
      end else if (rise[i]) begin
        stat_d[i] = 1'b1;
      end else if (ack_hit && (vec_q == VW'(i))) begin
        stat_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if ((|eligible) && int_enable && !clear_all) begin
          vec_d   = sel;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        unique case (1'b1)
          clear_all: begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
          int_ack: begin
            req_d   = 1'b0;
            state_d = HOLD;
          end
          (!int_enable || !mask_q[vec_q]): begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
          default: ;
        endcase
      end
      HOLD: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sync_q  <= '0;
      last_q  <= '0;
      mask_q  <= '0;
      stat_q  <= '0;
      req_q   <= 1'b0;
      vec_q   <= '0;
      state_q <= IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_in};
      last_q  <= sync_out;
      mask_q  <= mask_d;
      stat_q  <= stat_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      state_q <= state_d;
    end
  end

  assign irq_masks   = mask_q;
  assign irq_status  = stat_q;
  assign int_request = req_q;
  assign int_vector  = vec_q;

endmodule
